icache_fa_mshr: RTL and testbench
=================================

ICACHE_FA_MSHR -- requirements
Module: icache_fa_mshr

Interface
REQ-001 SHALL have parameter READ_PORTS, default 2: number of fetch read ports.
REQ-002 SHALL have parameter LINES, default 32: fully-associative cache lines, power of two, at least 2.
REQ-003 SHALL have parameter MSHRS, default 4: miss status holding registers, at most NUM_MEM_TAGS.
REQ-004 SHALL have clock  input  1  system clock.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have read_addr  input  READ_PORTS x ADDR  fetch addresses; tag = addr[31:3].
REQ-007 SHALL have read_en  input  READ_PORTS  per-port lookup request.
REQ-008 SHALL have cache_out  output  READ_PORTS x CACHE_DATA  {valid, line} per port.
REQ-009 SHALL have flush  input  1  invalidate the whole cache.
REQ-010 SHALL have mem_req_valid  output  1  memory request strobe.
REQ-011 SHALL have mem_req_addr  output  ADDR  line-aligned request address, low 3 bits zero.
REQ-012 SHALL have mem_req_command  output  MEM_COMMAND  MEM_LOAD when valid, MEM_NONE otherwise.
REQ-013 SHALL have Imem2proc_transaction_tag  input  MEM_TAG  same-cycle acceptance tag; 0 = rejected.
REQ-014 SHALL have Imem2proc_data  input  MEM_BLOCK  returned line.
REQ-015 SHALL have Imem2proc_data_tag  input  MEM_TAG  tag of returned data; 0 = none.
REQ-016 SHALL have mshr_free  output  $clog2(MSHRS)+1  count of MSHRs in FREE.

Function
REQ-017 Lookup SHALL be combinational: cache_out[p].valid=1 iff read_en[p] and a valid line's tag matches, or a fill for that tag writes this cycle (fill forwarding).
REQ-018 Each MSHR SHALL hold state FREE, REQ (awaiting issue) or WAIT (holding a memory tag), plus line tag and a drop bit.
REQ-019 A port miss SHALL allocate the lowest-index FREE MSHR to REQ next cycle, unless the tag is already in an MSHR or claimed by a lower-indexed port this cycle.
REQ-020 With no FREE MSHR, misses SHALL be dropped silently; fetch re-presents the address.
REQ-021 Allocation priority SHALL be port 0 first, then ascending.
REQ-022 Exactly one REQ MSHR, the oldest-allocated, SHALL drive mem_req_valid per cycle; non-zero transaction tag moves it to WAIT with that tag, 0 leaves it in REQ to retry next cycle.
REQ-023 Data tag matching a WAIT MSHR SHALL write Imem2proc_data into the cache next edge and return the MSHR to FREE; drop=1 frees without writing.
REQ-024 Unmatched non-zero data tags SHALL be ignored.
REQ-025 Fill victim SHALL be the lowest-index invalid line, else a round-robin victim pointer, which increments mod LINES on each eviction.
REQ-026 flush SHALL clear all line valids and the victim pointer next edge, return REQ MSHRs to FREE, and set drop on WAIT MSHRs; a same-cycle fill is discarded; no allocation occurs in a flush cycle.
REQ-027 Fill, allocation and request acceptance in one cycle SHALL all take effect; an MSHR freed by a fill is allocatable the following cycle.

Reset
REQ-028 Reset SHALL clear all line valids, set all MSHRs FREE with drop=0, set the victim pointer to 0 and the age order to empty.
REQ-029 During and after reset, mem_req_valid=0, mem_req_command=MEM_NONE, mem_req_addr=0, cache_out all zero, mshr_free=MSHRS.

Configuration
REQ-030 With ICACHE_NEXT_LINE_PREFETCH_EN defined, a demand allocation for line T SHALL also allocate line T+1 the same cycle if T+1 is neither cached nor in an MSHR and at least 2 MSHRs are FREE after demand allocation; prefetch is age-ordered after its demand.
REQ-031 Without ICACHE_NEXT_LINE_PREFETCH_EN, only demand misses allocate MSHRs.

Verification
REQ-032 Cold miss: read 0x100 on port 0, accept tag 3, data tag 3 three cycles later -> one MEM_LOAD at 0x100; valid on the fill cycle (forwarded) and on every later hit.
REQ-033 Same-line dual miss: ports 0 and 1 read 0x200 and 0x204 -> one MSHR, one request at 0x200, mshr_free drops by 1.
REQ-034 Rejection: transaction tag 0 for two cycles, then 5 -> mem_req_addr stays constant for three cycles; MSHR enters WAIT with tag 5.
REQ-035 MSHR full: MSHRS=4, four outstanding misses, fifth address missing -> no allocation, mshr_free=0; allocates the cycle after any fill.
REQ-036 Flush with WAIT outstanding: flush, then data tag returns -> no line written, the MSHR frees, a re-read of the address misses.
REQ-037 Eviction with LINES=4: fill five distinct lines -> fifth replaces line 0, pointer becomes 1; with prefetch on, miss at 0x300 also requests 0x308.

Source files
------------

// File: rtl/icache_fa_mshr_if.sv
// icache_fa_mshr_if -- instruction-cache to memory bus.
//
// Signals:
//   mem_req_valid             cache -> mem  request strobe
//   mem_req_addr              cache -> mem  line-aligned address (low 3 bits zero)
//   mem_req_command           cache -> mem  MEM_LOAD (1) when valid, MEM_NONE (0) otherwise
//   Imem2proc_transaction_tag mem -> cache  same-cycle acceptance tag, 0 = rejected
//   Imem2proc_data            mem -> cache  returned 64-bit line
//   Imem2proc_data_tag        mem -> cache  tag of returned data, 0 = no data
//
// Handshake: a request is transferred in the cycle where mem_req_valid=1 and
// Imem2proc_transaction_tag!=0 (the non-zero tag plays the role of ready).
// While the tag is 0 the cache holds mem_req_valid/addr stable and retries.
// Responses are unconditionally accepted in the cycle Imem2proc_data_tag!=0.
//
// Modports: master = cache side, slave = memory side.
interface icache_fa_mshr_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_command;
  logic [3:0]  Imem2proc_transaction_tag;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_data_tag;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_command,
    input  Imem2proc_transaction_tag, Imem2proc_data, Imem2proc_data_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_command,
    output Imem2proc_transaction_tag, Imem2proc_data, Imem2proc_data_tag
  );
endinterface

// File: rtl/icache_fa_mshr.sv
// icache_fa_mshr -- fully-associative instruction cache with MSHR-tracked misses.
//
// Parameters:
//   READ_PORTS  number of fetch read ports (default 2)
//   LINES       cache lines, power of two, >= 2 (default 32)
//   MSHRS       miss status holding registers, <= number of memory tags (default 4)
//
// Ports:
//   clock, reset    system clock; synchronous active-high reset
//   read_addr[p]    fetch address per port; line tag = addr[31:3]
//   read_en[p]      lookup request per port
//   cache_out[p]    {valid, line} per port; all zero when not a hit
//   flush           invalidate whole cache, cancel/neutralise outstanding misses
//   mshr_free       number of MSHRs in FREE
//   mshr_state_dbg  per-MSHR state (0 FREE, 1 REQ, 2 WAIT) for observation
//   mem             icache_fa_mshr_if.master memory request/response bus
//
// Optional feature: define ICACHE_NEXT_LINE_PREFETCH_EN to let each demand
// allocation for line T also allocate line T+1 when enough MSHRs are free.
module icache_fa_mshr #(
  parameter int READ_PORTS = 2,
  parameter int LINES      = 32,
  parameter int MSHRS      = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [READ_PORTS-1:0][31:0]        read_addr,
  input  logic [READ_PORTS-1:0]              read_en,
  output logic [READ_PORTS-1:0][64:0]        cache_out,
  input  logic                               flush,
  output logic [$clog2(MSHRS):0]             mshr_free,
  output logic [MSHRS-1:0][1:0]              mshr_state_dbg,
  icache_fa_mshr_if.master                   mem
);

  localparam int TAG_W  = 29;
  localparam int LIDX_W = $clog2(LINES);
  localparam int MIDX_W = (MSHRS > 1) ? $clog2(MSHRS) : 1;
  localparam int CNT_W  = $clog2(MSHRS) + 1;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef enum logic [1:0] {
    MSHR_FREE = 2'd0,
    MSHR_REQ  = 2'd1,
    MSHR_WAIT = 2'd2
  } mshr_state_t;

  // Cache storage
  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [63:0]       line_data [LINES];
  logic [LIDX_W-1:0] victim_ptr;

  // MSHR storage and next state
  mshr_state_t      mshr_state   [MSHRS];
  mshr_state_t      mshr_state_n [MSHRS];
  logic [TAG_W-1:0] mshr_tag     [MSHRS];
  logic [TAG_W-1:0] mshr_tag_n   [MSHRS];
  logic [3:0]       mshr_mtag    [MSHRS];
  logic [3:0]       mshr_mtag_n  [MSHRS];
  logic             mshr_drop    [MSHRS];
  logic             mshr_drop_n  [MSHRS];

  // Age order: MSHR indices in REQ state, oldest at slot 0.
  logic [MIDX_W-1:0] age_q   [MSHRS];
  logic [MIDX_W-1:0] age_q_n [MSHRS];
  logic [CNT_W-1:0]  age_cnt;
  logic [CNT_W-1:0]  age_cnt_n;

  // Fill path
  logic              fill_hit;
  logic              fill_write;
  logic [MIDX_W-1:0] fill_mshr;
  logic [TAG_W-1:0]  fill_tag;
  logic [LIDX_W-1:0] victim;
  logic              evict;

  // Lookup path
  logic [TAG_W-1:0]  port_tag  [READ_PORTS];
  logic [63:0]       port_data [READ_PORTS];
  logic [READ_PORTS-1:0] port_hit;

  // Request path
  logic              req_valid;
  logic [MIDX_W-1:0] req_head;
  logic              req_accept;

  // Allocation scratch
  int                a_cnt;
  logic [MSHRS-1:0]  a_avail;
  logic [2*READ_PORTS-1:0] a_claim_v;
  logic [TAG_W-1:0]  a_claim_tag [2*READ_PORTS];
  logic [TAG_W-1:0]  a_tag;
  logic              a_dup;
  logic              a_got;
  logic [MIDX_W-1:0] a_idx;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
  logic [TAG_W-1:0]  a_pf_tag;
  logic              a_pf_dup;
  logic              a_pf_got;
  logic [MIDX_W-1:0] a_pf_idx;
  int                a_pf_free;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^read_addr;

  // ---------------------------------------------------------------------------
  // Fill match: a returned data tag completes the WAIT MSHR holding it. A
  // dropped MSHR or a flush in the same cycle consumes the data without a write.
  // ---------------------------------------------------------------------------
  always_comb begin
    fill_hit  = 1'b0;
    fill_mshr = '0;
    for (int m = MSHRS-1; m >= 0; m--) begin
      if (mshr_state[m] == MSHR_WAIT && mem.Imem2proc_data_tag != 4'd0 &&
          mshr_mtag[m] == mem.Imem2proc_data_tag) begin
        fill_hit  = 1'b1;
        fill_mshr = MIDX_W'(m);
      end
    end
    fill_tag   = mshr_tag[fill_mshr];
    fill_write = fill_hit && !mshr_drop[fill_mshr] && !flush;
  end

  // Victim: lowest invalid line, otherwise the round-robin pointer.
  always_comb begin
    victim = victim_ptr;
    evict  = 1'b1;
    for (int l = LINES-1; l >= 0; l--) begin
      if (!line_valid[l]) begin
        victim = LIDX_W'(l);
        evict  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational lookup with forwarding of the line being filled this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      port_tag[p]  = read_addr[p][31:3];
      port_hit[p]  = 1'b0;
      port_data[p] = '0;
      for (int l = 0; l < LINES; l++) begin
        if (line_valid[l] && line_tag[l] == port_tag[p]) begin
          port_hit[p]  = 1'b1;
          port_data[p] = line_data[l];
        end
      end
      if (fill_write && fill_tag == port_tag[p]) begin
        port_hit[p]  = 1'b1;
        port_data[p] = mem.Imem2proc_data;
      end
      port_hit[p]  = port_hit[p] & read_en[p];
      cache_out[p] = (reset || !port_hit[p]) ? 65'd0 : {1'b1, port_data[p]};
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request: the oldest REQ MSHR drives the bus.
  // ---------------------------------------------------------------------------
  assign req_valid  = !reset && (age_cnt != '0);
  assign req_head   = age_q[0];
  assign req_accept = req_valid && (mem.Imem2proc_transaction_tag != 4'd0);

  assign mem.mem_req_valid   = req_valid;
  assign mem.mem_req_addr    = req_valid ? {mshr_tag[req_head], 3'b000} : 32'd0;
  assign mem.mem_req_command = req_valid ? MEM_LOAD : MEM_NONE;

  // ---------------------------------------------------------------------------
  // MSHR next state: acceptance, fill completion, flush, then allocation.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int m = 0; m < MSHRS; m++) begin
      mshr_state_n[m] = mshr_state[m];
      mshr_tag_n[m]   = mshr_tag[m];
      mshr_mtag_n[m]  = mshr_mtag[m];
      mshr_drop_n[m]  = mshr_drop[m];
      age_q_n[m]      = age_q[m];
      a_avail[m]      = (mshr_state[m] == MSHR_FREE);
    end
    a_cnt     = int'(age_cnt);
    a_claim_v = '0;
    for (int c = 0; c < 2*READ_PORTS; c++) a_claim_tag[c] = '0;
    a_tag = '0;
    a_dup = 1'b0;
    a_got = 1'b0;
    a_idx = '0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    a_pf_tag  = '0;
    a_pf_dup  = 1'b0;
    a_pf_got  = 1'b0;
    a_pf_idx  = '0;
    a_pf_free = 0;
`endif

    if (req_accept) begin
      mshr_state_n[req_head] = MSHR_WAIT;
      mshr_mtag_n[req_head]  = mem.Imem2proc_transaction_tag;
      for (int i = 0; i < MSHRS-1; i++) age_q_n[i] = age_q[i+1];
      age_q_n[MSHRS-1] = '0;
      a_cnt = a_cnt - 1;
    end

    if (fill_hit) begin
      mshr_state_n[fill_mshr] = MSHR_FREE;
      mshr_drop_n[fill_mshr]  = 1'b0;
    end

    if (flush) begin
      // Unissued misses vanish; issued ones must still absorb their data.
      for (int m = 0; m < MSHRS; m++) begin
        if (mshr_state_n[m] == MSHR_REQ)  mshr_state_n[m] = MSHR_FREE;
        if (mshr_state_n[m] == MSHR_WAIT) mshr_drop_n[m]  = 1'b1;
      end
      a_cnt = 0;
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (read_en[p] && !port_hit[p]) begin
          a_tag = port_tag[p];
          a_dup = 1'b0;
          for (int m = 0; m < MSHRS; m++)
            if (mshr_state[m] != MSHR_FREE && mshr_tag[m] == a_tag) a_dup = 1'b1;
          for (int c = 0; c < 2*READ_PORTS; c++)
            if (a_claim_v[c] && a_claim_tag[c] == a_tag) a_dup = 1'b1;
          a_got = 1'b0;
          a_idx = '0;
          for (int m = MSHRS-1; m >= 0; m--) begin
            if (a_avail[m]) begin
              a_got = 1'b1;
              a_idx = MIDX_W'(m);
            end
          end
          if (!a_dup && a_got) begin
            a_avail[a_idx]         = 1'b0;
            mshr_state_n[a_idx]    = MSHR_REQ;
            mshr_tag_n[a_idx]      = a_tag;
            mshr_drop_n[a_idx]     = 1'b0;
            age_q_n[MIDX_W'(a_cnt)] = a_idx;
            a_cnt                  = a_cnt + 1;
            a_claim_v[2*p]         = 1'b1;
            a_claim_tag[2*p]       = a_tag;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            // Next-line prefetch, queued directly behind its demand miss.
            a_pf_tag = a_tag + TAG_W'(1);
            a_pf_dup = 1'b0;
            for (int l = 0; l < LINES; l++)
              if (line_valid[l] && line_tag[l] == a_pf_tag) a_pf_dup = 1'b1;
            if (fill_write && fill_tag == a_pf_tag) a_pf_dup = 1'b1;
            for (int m = 0; m < MSHRS; m++)
              if (mshr_state[m] != MSHR_FREE && mshr_tag[m] == a_pf_tag) a_pf_dup = 1'b1;
            for (int c = 0; c < 2*READ_PORTS; c++)
              if (a_claim_v[c] && a_claim_tag[c] == a_pf_tag) a_pf_dup = 1'b1;
            a_pf_free = 0;
            a_pf_got  = 1'b0;
            a_pf_idx  = '0;
            for (int m = MSHRS-1; m >= 0; m--) begin
              if (a_avail[m]) begin
                a_pf_free = a_pf_free + 1;
                a_pf_got  = 1'b1;
                a_pf_idx  = MIDX_W'(m);
              end
            end
            if (!a_pf_dup && a_pf_got && a_pf_free >= 2) begin
              a_avail[a_pf_idx]       = 1'b0;
              mshr_state_n[a_pf_idx]  = MSHR_REQ;
              mshr_tag_n[a_pf_idx]    = a_pf_tag;
              mshr_drop_n[a_pf_idx]   = 1'b0;
              age_q_n[MIDX_W'(a_cnt)] = a_pf_idx;
              a_cnt                   = a_cnt + 1;
              a_claim_v[2*p+1]        = 1'b1;
              a_claim_tag[2*p+1]      = a_pf_tag;
            end
`endif
          end
        end
      end
    end
    age_cnt_n = CNT_W'(a_cnt);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid <= '0;
      victim_ptr <= '0;
      age_cnt    <= '0;
      for (int m = 0; m < MSHRS; m++) begin
        mshr_state[m] <= MSHR_FREE;
        mshr_tag[m]   <= '0;
        mshr_mtag[m]  <= '0;
        mshr_drop[m]  <= 1'b0;
        age_q[m]      <= '0;
      end
    end else begin
      age_cnt <= age_cnt_n;
      for (int m = 0; m < MSHRS; m++) begin
        mshr_state[m] <= mshr_state_n[m];
        mshr_tag[m]   <= mshr_tag_n[m];
        mshr_mtag[m]  <= mshr_mtag_n[m];
        mshr_drop[m]  <= mshr_drop_n[m];
        age_q[m]      <= age_q_n[m];
      end
      if (flush) begin
        line_valid <= '0;
        victim_ptr <= '0;
      end else if (fill_write) begin
        line_valid[victim] <= 1'b1;
        if (evict) victim_ptr <= victim_ptr + LIDX_W'(1);
      end
    end
  end

  // Tag/data arrays carry no reset; they are qualified by line_valid.
  always_ff @(posedge clock) begin
    if (!reset && fill_write) begin
      line_tag[victim]  <= fill_tag;
      line_data[victim] <= mem.Imem2proc_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    int n;
    n = 0;
    for (int m = 0; m < MSHRS; m++) begin
      if (mshr_state[m] == MSHR_FREE) n = n + 1;
      mshr_state_dbg[m] = mshr_state[m];
    end
    mshr_free = reset ? CNT_W'(MSHRS) : CNT_W'(n);
  end

endmodule

// File: tb/tb_icache_fa_mshr.sv
// tb_icache_fa_mshr -- directed bench for icache_fa_mshr (READ_PORTS=2,
// LINES=4, MSHRS=4). Inputs change 1 time unit after each rising edge and
// outputs are compared 1 unit later; expected request addresses flow through
// exp_q in allocation order.
module tb_icache_fa_mshr;
  logic             clock = 1'b0;
  logic             reset;
  logic [1:0][31:0] read_addr;
  logic [1:0]       read_en;
  logic [1:0][64:0] cache_out;
  logic             flush;
  logic [2:0]       mshr_free;
  logic [3:0][1:0]  mshr_state_dbg;

  icache_fa_mshr_if mem_if ();

  icache_fa_mshr #(.READ_PORTS(2), .LINES(4), .MSHRS(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .read_addr      (read_addr),
    .read_en        (read_en),
    .cache_out      (cache_out),
    .flush          (flush),
    .mshr_free      (mshr_free),
    .mshr_state_dbg (mshr_state_dbg),
    .mem            (mem_if)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    read_en   = '0;
    read_addr = '0;
    flush     = 1'b0;
    mem_if.Imem2proc_transaction_tag = 4'd0;
    mem_if.Imem2proc_data_tag        = 4'd0;
    mem_if.Imem2proc_data            = 64'd0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    read_en[p]   = 1'b1;
    read_addr[p] = a;
  endtask

  // Check the head request against the scoreboard; mtag!=0 accepts it.
  task automatic expect_req(input logic [3:0] mtag, input bit pop);
    logic [31:0] e;
    mem_if.Imem2proc_transaction_tag = mtag;
    #1;
    e = (exp_q.size() != 0) ? exp_q[0] : 32'hdead_beef;
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    check("req_valid", mem_if.mem_req_valid, 1'b1);
    check("req_cmd", mem_if.mem_req_command, 2'd1);
    check("req_addr", mem_if.mem_req_addr, e);
  endtask

  task automatic give_data(input logic [3:0] mtag, input logic [63:0] d);
    mem_if.Imem2proc_data_tag = mtag;
    mem_if.Imem2proc_data     = d;
  endtask

  // Miss, accept, fill with forwarding: three cycles.
  task automatic fill_line(input logic [31:0] a, input logic [3:0] mtag, input logic [63:0] d);
    rd(0, a);
    exp_q.push_back(a);
    #1;
    check("fl_miss", cache_out[0], 65'd0);
    next_cycle();
    expect_req(mtag, 1'b1);
    next_cycle();
    give_data(mtag, d);
    rd(0, a);
    #1;
    check("fl_fwd", cache_out[0], {1'b1, d});
    next_cycle();
  endtask

  initial begin
    idle();
    // ---------------- reset ----------------
    reset = 1'b1;
    rd(0, 32'h100);
    rd(1, 32'h108);
    mem_if.Imem2proc_transaction_tag = 4'd3;
    mem_if.Imem2proc_data_tag        = 4'd3;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_valid", mem_if.mem_req_valid, 1'b0);
    check("rst_cmd", mem_if.mem_req_command, 2'd0);
    check("rst_addr", mem_if.mem_req_addr, 32'd0);
    check("rst_cache_out", cache_out, 130'd0);
    check("rst_mshr_free", mshr_free, 3'd4);
    next_cycle();
    reset = 1'b0;
    #1;
    check("post_rst_valid", mem_if.mem_req_valid, 1'b0);
    check("post_rst_free", mshr_free, 3'd4);
    check("post_rst_state", mshr_state_dbg, 8'd0);
    next_cycle();

    // ---------------- cold miss 0x100 ----------------
    rd(0, 32'h100);
    exp_q.push_back(32'h100);
    #1;
    check("cold_miss", cache_out[0], 65'd0);
    next_cycle();
    expect_req(4'd3, 1'b1);
    check("cold_free", mshr_free, 3'd3);
    next_cycle();
    #1;
    check("cold_one_req", mem_if.mem_req_valid, 1'b0);
    next_cycle();
    next_cycle();
    give_data(4'd3, 64'h1111_0000_0000_0100);
    rd(0, 32'h100);
    #1;
    check("cold_fwd", cache_out[0], {1'b1, 64'h1111_0000_0000_0100});
    next_cycle();
    rd(0, 32'h100);
    rd(1, 32'h104);
    #1;
    check("cold_hit0", cache_out[0], {1'b1, 64'h1111_0000_0000_0100});
    check("cold_hit1", cache_out[1], {1'b1, 64'h1111_0000_0000_0100});
    check("cold_free_back", mshr_free, 3'd4);
    next_cycle();

    // ---------------- same-line dual miss ----------------
    rd(0, 32'h200);
    rd(1, 32'h204);
    exp_q.push_back(32'h200);
    #1;
    check("dual_miss", cache_out, 130'd0);
    next_cycle();
    check("dual_free", mshr_free, 3'd3);
    expect_req(4'd4, 1'b1);
    next_cycle();
    #1;
    check("dual_one_req", mem_if.mem_req_valid, 1'b0);
    check("dual_free2", mshr_free, 3'd3);
    next_cycle();
    give_data(4'd4, 64'h2222_0000_0000_0200);
    rd(1, 32'h204);
    #1;
    check("dual_fwd", cache_out[1], {1'b1, 64'h2222_0000_0000_0200});
    next_cycle();

    // ---------------- rejection then accept ----------------
    rd(0, 32'h180);
    exp_q.push_back(32'h180);
    next_cycle();
    expect_req(4'd0, 1'b0);
    next_cycle();
    expect_req(4'd0, 1'b0);
    next_cycle();
    expect_req(4'd5, 1'b1);
    next_cycle();
    give_data(4'd6, 64'hbad0_bad0_bad0_bad0);
    rd(0, 32'h180);
    #1;
    check("rej_wait_state", mshr_state_dbg[0], 2'd2);
    check("rej_no_req", mem_if.mem_req_valid, 1'b0);
    check("stray_tag_ignored", cache_out[0], 65'd0);
    next_cycle();
    give_data(4'd5, 64'h3333_0000_0000_0180);
    rd(0, 32'h180);
    #1;
    check("rej_fwd", cache_out[0], {1'b1, 64'h3333_0000_0000_0180});
    next_cycle();

    // ---------------- MSHR full ----------------
    rd(0, 32'h400); rd(1, 32'h408);
    exp_q.push_back(32'h400); exp_q.push_back(32'h408);
    next_cycle();
    rd(0, 32'h410); rd(1, 32'h418);
    exp_q.push_back(32'h410); exp_q.push_back(32'h418);
    #1;
    check("full_free2", mshr_free, 3'd2);
    next_cycle();
    rd(0, 32'h420);
    check("full_free0", mshr_free, 3'd0);
    expect_req(4'd6, 1'b1);
    next_cycle();
    rd(0, 32'h420);
    check("full_no_alloc", mshr_free, 3'd0);
    expect_req(4'd7, 1'b1);
    next_cycle();
    expect_req(4'd8, 1'b1);
    next_cycle();
    expect_req(4'd9, 1'b1);
    next_cycle();
    rd(0, 32'h420);
    give_data(4'd6, 64'h4444_0000_0000_0400);
    #1;
    check("full_fill_cycle_free", mshr_free, 3'd0);
    check("full_420_miss", cache_out[0], 65'd0);
    next_cycle();
    rd(0, 32'h420);
    exp_q.push_back(32'h420);
    #1;
    check("full_freed", mshr_free, 3'd1);
    next_cycle();
    check("full_realloc", mshr_free, 3'd0);
    expect_req(4'd0, 1'b1);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    give_data(4'd7, 64'h5555_5555_5555_5555);
    #1;
    check("flush_req_freed", mshr_free, 3'd1);
    check("flush_no_req", mem_if.mem_req_valid, 1'b0);
    next_cycle();
    give_data(4'd8, 64'h6666_6666_6666_6666);
    next_cycle();
    give_data(4'd9, 64'h7777_7777_7777_7777);
    next_cycle();
    rd(0, 32'h100);
    rd(1, 32'h408);
    #1;
    check("drop_all_free", mshr_free, 3'd4);
    check("flush_cleared", cache_out, 130'd0);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    #1;
    check("flush_frees_req", mshr_free, 3'd4);
    next_cycle();

    // ---------------- flush with WAIT outstanding ----------------
    rd(0, 32'h600);
    exp_q.push_back(32'h600);
    next_cycle();
    expect_req(4'd11, 1'b1);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    give_data(4'd11, 64'h8888_0000_0000_0600);
    rd(0, 32'h600);
    #1;
    check("drop_no_fwd", cache_out[0], 65'd0);
    check("drop_still_wait", mshr_free, 3'd3);
    next_cycle();
    rd(0, 32'h600);
    exp_q.push_back(32'h600);
    #1;
    check("drop_reread_miss", cache_out[0], 65'd0);
    check("drop_freed", mshr_free, 3'd4);
    next_cycle();
    check("drop_realloc", mshr_free, 3'd3);
    expect_req(4'd0, 1'b1);
    flush = 1'b1;
    next_cycle();
    #1;
    check("drop_flush_free", mshr_free, 3'd4);
    next_cycle();

    // ---------------- eviction, LINES=4 ----------------
    fill_line(32'h500, 4'd1, 64'hE0);
    fill_line(32'h508, 4'd2, 64'hE1);
    fill_line(32'h510, 4'd3, 64'hE2);
    fill_line(32'h518, 4'd4, 64'hE3);
    fill_line(32'h520, 4'd5, 64'hE4);
    rd(0, 32'h508);
    rd(1, 32'h520);
    #1;
    check("ev_keep_508", cache_out[0], {1'b1, 64'hE1});
    check("ev_new_520", cache_out[1], {1'b1, 64'hE4});
    next_cycle();
    fill_line(32'h528, 4'd6, 64'hE5);
    rd(0, 32'h510);
    rd(1, 32'h528);
    #1;
    check("ev_keep_510", cache_out[0], {1'b1, 64'hE2});
    check("ev_new_528", cache_out[1], {1'b1, 64'hE5});
    next_cycle();
    rd(0, 32'h500);
    rd(1, 32'h508);
    #1;
    check("ev_lost_500", cache_out[0][64], 1'b0);
    check("ev_lost_508", cache_out[1][64], 1'b0);
    next_cycle();
    flush = 1'b1;
    next_cycle();

    // ---------------- next-line prefetch ----------------
    rd(0, 32'h300);
    exp_q.push_back(32'h300);
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    exp_q.push_back(32'h308);
`endif
    next_cycle();
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    check("pf_free", mshr_free, 3'd2);
`else
    check("pf_free", mshr_free, 3'd3);
`endif
    expect_req(4'd7, 1'b1);
    next_cycle();
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    expect_req(4'd8, 1'b1);
`else
    #1;
    check("pf_none", mem_if.mem_req_valid, 1'b0);
`endif
    next_cycle();
    flush = 1'b1;
    next_cycle();
    give_data(4'd7, 64'h0);
    next_cycle();
    give_data(4'd8, 64'h0);
    next_cycle();
    #1;
    check("pf_drained", mshr_free, 3'd4);
    check("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
